// File: rtl/riscv_multicycle_top.sv
`default_nettype none
// ============================================================================
// riscv_multicycle_top
// Multi-cycle RV32I-subset CPU: FSM-sequenced core with one shared ALU and a
// unified word-addressed instruction/data memory.
// Revision: 1.0
// ============================================================================

package riscv_mc_pkg;
    typedef enum logic {
        PC_SRC__ALU_OUT    = 1'b0,
        PC_SRC__ALU_RESULT = 1'b1
    } pc_src_t;

    localparam logic [6:0] c_OPC_LOAD  = 7'h03;
    localparam logic [6:0] c_OPC_OPIMM = 7'h13;
    localparam logic [6:0] c_OPC_STORE = 7'h23;
    localparam logic [6:0] c_OPC_OP    = 7'h33;
    localparam logic [6:0] c_OPC_LUI   = 7'h37;
    localparam logic [6:0] c_OPC_BR    = 7'h63;
    localparam logic [6:0] c_OPC_JALR  = 7'h67;
    localparam logic [6:0] c_OPC_JAL   = 7'h6F;

    localparam logic [1:0] c_SRCA_PC    = 2'd0;
    localparam logic [1:0] c_SRCA_OLDPC = 2'd1;
    localparam logic [1:0] c_SRCA_RS1   = 2'd2;
    localparam logic [1:0] c_SRCA_ZERO  = 2'd3;

    localparam logic [1:0] c_SRCB_RS2  = 2'd0;
    localparam logic [1:0] c_SRCB_IMM  = 2'd1;
    localparam logic [1:0] c_SRCB_FOUR = 2'd2;

    localparam logic [1:0] c_ALUOP_ADD   = 2'd0;
    localparam logic [1:0] c_ALUOP_SUB   = 2'd1;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'd2;

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_XOR = 3'd4;
    localparam logic [2:0] c_ALU_SLT = 3'd5;
endpackage

module riscv_mc_control_fsm
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    output logic       o_ir_write,
    output logic       o_pc_update,
    output pc_src_t    o_pc_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic       o_reg_write,
    output logic       o_result_src,
    output logic       o_mem_write,
    output logic       o_addr_src
);
    localparam logic [3:0] FETCH      = 4'd0;
    localparam logic [3:0] DECODE     = 4'd1;
    localparam logic [3:0] MEMADR     = 4'd2;
    localparam logic [3:0] MEMREAD    = 4'd3;
    localparam logic [3:0] MEMWB      = 4'd4;
    localparam logic [3:0] MEMWRITE   = 4'd5;
    localparam logic [3:0] EXECUTER   = 4'd6;
    localparam logic [3:0] EXECUTEI   = 4'd7;
    localparam logic [3:0] ALUWB      = 4'd8;
    localparam logic [3:0] BRANCH     = 4'd9;
    localparam logic [3:0] JAL        = 4'd10;
    localparam logic [3:0] JALR_CALC  = 4'd11;
    localparam logic [3:0] JALR_STEP2 = 4'd12;
    localparam logic [3:0] LUI        = 4'd13;

    logic [3:0] current_state;
    logic [3:0] w_next_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) current_state <= FETCH;
        else        current_state <= w_next_state;
    end

    always_comb begin
        w_next_state = FETCH;
        o_ir_write   = 1'b0;
        o_pc_update  = 1'b0;
        o_pc_src     = PC_SRC__ALU_OUT;
        o_alu_src_a  = c_SRCA_RS1;
        o_alu_src_b  = c_SRCB_IMM;
        o_alu_op     = c_ALUOP_ADD;
        o_reg_write  = 1'b0;
        o_result_src = 1'b0;
        o_mem_write  = 1'b0;
        o_addr_src   = 1'b0;
        case (current_state)
            FETCH: begin
                o_ir_write   = 1'b1;
                o_alu_src_a  = c_SRCA_PC;
                o_alu_src_b  = c_SRCB_FOUR;
                w_next_state = DECODE;
            end
            DECODE: begin
                // Speculative branch/JAL target, consumed by BRANCH or JAL
                o_alu_src_a = c_SRCA_OLDPC;
                case (i_opcode)
                    c_OPC_OP:    w_next_state = EXECUTER;
                    c_OPC_OPIMM: w_next_state = EXECUTEI;
                    c_OPC_LOAD,
                    c_OPC_STORE: w_next_state = MEMADR;
                    c_OPC_BR:    w_next_state = BRANCH;
                    c_OPC_JAL:   w_next_state = JAL;
                    c_OPC_JALR:  w_next_state = JALR_CALC;
                    c_OPC_LUI:   w_next_state = LUI;
                    default:     w_next_state = FETCH;
                endcase
            end
            MEMADR:
                w_next_state = (i_opcode == c_OPC_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                o_addr_src   = 1'b1;
                w_next_state = MEMWB;
            end
            MEMWB: begin
                o_reg_write  = 1'b1;
                o_result_src = 1'b1;
            end
            MEMWRITE: begin
                o_addr_src  = 1'b1;
                o_mem_write = 1'b1;
            end
            EXECUTER: begin
                o_alu_src_b  = c_SRCB_RS2;
                o_alu_op     = c_ALUOP_FUNCT;
                w_next_state = ALUWB;
            end
            EXECUTEI: begin
                o_alu_op     = c_ALUOP_FUNCT;
                w_next_state = ALUWB;
            end
            ALUWB:
                o_reg_write = 1'b1;
            BRANCH: begin
                o_alu_src_b = c_SRCB_RS2;
                o_alu_op    = c_ALUOP_SUB;
                o_pc_src    = PC_SRC__ALU_RESULT;
                o_pc_update = ((i_funct3 == 3'b000) &&  i_zero) ||
                              ((i_funct3 == 3'b001) && !i_zero);
            end
            JAL, JALR_STEP2: begin
                o_pc_update  = 1'b1;
                o_pc_src     = PC_SRC__ALU_RESULT;
                o_alu_src_a  = c_SRCA_OLDPC;
                o_alu_src_b  = c_SRCB_FOUR;
                w_next_state = ALUWB;
            end
            JALR_CALC:
                w_next_state = JALR_STEP2;
            LUI: begin
                o_alu_src_a  = c_SRCA_ZERO;
                w_next_state = ALUWB;
            end
            default:
                w_next_state = FETCH;
        endcase
    end
endmodule

module riscv_mc_fetch
    import riscv_mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ir_write,
    input  logic        i_pc_update,
    input  pc_src_t     i_pc_src,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] pc_cur,
    output logic [31:0] o_pc_old,
    output logic [31:0] o_ir
);
    logic [31:0] r_pc_old;
    logic [31:0] r_ir;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_cur   <= 32'd0;
            r_pc_old <= 32'd0;
            r_ir     <= 32'd0;
        end else if (i_ir_write) begin
            r_ir     <= i_mem_rdata;
            r_pc_old <= pc_cur;
            pc_cur   <= i_alu_out;
        end else if (i_pc_update) begin
            // Bit 0 is cleared for JALR; JAL/branch targets are already even
            pc_cur <= (i_pc_src == PC_SRC__ALU_RESULT) ? (i_alu_result & ~32'd1)
                                                       : i_alu_out;
        end
    end

    assign o_pc_old = r_pc_old;
    assign o_ir     = r_ir;
endmodule

module riscv_mc_decoder
    import riscv_mc_pkg::*;
(
    input  logic [31:0]        i_instr,
    output logic [4:0]         rs1,
    output logic [4:0]         o_rs2,
    output logic [4:0]         rd,
    output logic [2:0]         o_funct3,
    output logic               o_funct7_b5,
    output logic signed [31:0] imm_ext
);
    assign rs1         = i_instr[19:15];
    assign o_rs2       = i_instr[24:20];
    assign rd          = i_instr[11:7];
    assign o_funct3    = i_instr[14:12];
    assign o_funct7_b5 = i_instr[30];

    always_comb begin
        imm_ext = {{20{i_instr[31]}}, i_instr[31:20]};
        case (i_instr[6:0])
            c_OPC_STORE: imm_ext = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            c_OPC_BR:    imm_ext = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                    i_instr[30:25], i_instr[11:8], 1'b0};
            c_OPC_JAL:   imm_ext = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                    i_instr[20], i_instr[30:21], 1'b0};
            c_OPC_LUI:   imm_ext = {i_instr[31:12], 12'd0};
            default:     imm_ext = {{20{i_instr[31]}}, i_instr[31:20]};
        endcase
    end
endmodule

module riscv_mc_regfile (
    input  logic        clk,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic        i_we,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] RFMem [0:31];

    always_ff @(posedge clk) begin
        if (i_we && (i_wa != 5'd0)) RFMem[i_wa] <= i_wd;
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : RFMem[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : RFMem[i_ra2];
endmodule

module riscv_mc_alu
    import riscv_mc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  i_ctrl,
    output logic [31:0] out,
    output logic        o_zero
);
    always_comb begin
        out = a + b;
        case (i_ctrl)
            c_ALU_SUB: out = a - b;
            c_ALU_AND: out = a & b;
            c_ALU_OR:  out = a | b;
            c_ALU_XOR: out = a ^ b;
            c_ALU_SLT: out = {31'd0, $signed(a) < $signed(b)};
            default:   out = a + b;
        endcase
    end

    assign o_zero = (out == 32'd0);
endmodule

module riscv_mc_memory #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    output logic [31:0] o_rdata
);
    localparam int c_ADDR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]         M [0:MEM_WORDS-1];
    logic [31:0]         w_word;
    logic [c_ADDR_W-1:0] w_idx;
    logic                w_unused;

    assign w_word   = {2'b00, i_addr[31:2]} % 32'(MEM_WORDS);
    assign w_idx    = w_word[c_ADDR_W-1:0];
    assign w_unused = &{1'b0, i_addr[1:0], w_word[31:c_ADDR_W], 1'b0};

    always_ff @(posedge clk) begin
        if (i_we) M[w_idx] <= i_wdata;
    end

    assign o_rdata = M[w_idx];
endmodule

module riscv_mc_core
    import riscv_mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we
);
    logic [6:0]         opcode;
    logic               cfsm__pc_update;
    pc_src_t            cfsm__pc_src;
    logic               w_ir_write, w_reg_write, w_result_src, w_mem_write, w_addr_src;
    logic [1:0]         w_alu_src_a, w_alu_src_b, w_alu_op;
    logic [31:0]        w_ir, w_pc_cur, w_pc_old;
    logic [4:0]         w_rs1, w_rs2, w_rd;
    logic [2:0]         w_funct3;
    logic               w_funct7_b5;
    logic signed [31:0] w_imm_ext;
    logic [31:0]        w_rd1, w_rd2;
    logic [31:0]        w_alu_a, w_alu_b, w_alu_out;
    logic               w_alu_zero;
    logic [2:0]         w_alu_ctrl;
    logic [31:0]        r_alu_result;
    logic [31:0]        r_data;

    assign opcode = w_ir[6:0];

    riscv_mc_control_fsm control_fsm (
        .clk          (clk),
        .reset        (reset),
        .i_opcode     (opcode),
        .i_funct3     (w_funct3),
        .i_zero       (w_alu_zero),
        .o_ir_write   (w_ir_write),
        .o_pc_update  (cfsm__pc_update),
        .o_pc_src     (cfsm__pc_src),
        .o_alu_src_a  (w_alu_src_a),
        .o_alu_src_b  (w_alu_src_b),
        .o_alu_op     (w_alu_op),
        .o_reg_write  (w_reg_write),
        .o_result_src (w_result_src),
        .o_mem_write  (w_mem_write),
        .o_addr_src   (w_addr_src)
    );

    riscv_mc_fetch fetch (
        .clk          (clk),
        .reset        (reset),
        .i_ir_write   (w_ir_write),
        .i_pc_update  (cfsm__pc_update),
        .i_pc_src     (cfsm__pc_src),
        .i_alu_out    (w_alu_out),
        .i_alu_result (r_alu_result),
        .i_mem_rdata  (i_mem_rdata),
        .pc_cur       (w_pc_cur),
        .o_pc_old     (w_pc_old),
        .o_ir         (w_ir)
    );

    riscv_mc_decoder instruction_decode (
        .i_instr     (w_ir),
        .rs1         (w_rs1),
        .o_rs2       (w_rs2),
        .rd          (w_rd),
        .o_funct3    (w_funct3),
        .o_funct7_b5 (w_funct7_b5),
        .imm_ext     (w_imm_ext)
    );

    riscv_mc_regfile RegFile (
        .clk   (clk),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .i_wa  (w_rd),
        .i_wd  (w_result_src ? r_data : r_alu_result),
        .i_we  (w_reg_write),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    always_comb begin
        case (w_alu_src_a)
            c_SRCA_PC:    w_alu_a = w_pc_cur;
            c_SRCA_OLDPC: w_alu_a = w_pc_old;
            c_SRCA_RS1:   w_alu_a = w_rd1;
            default:      w_alu_a = 32'd0;
        endcase
        case (w_alu_src_b)
            c_SRCB_RS2:  w_alu_b = w_rd2;
            c_SRCB_IMM:  w_alu_b = w_imm_ext;
            c_SRCB_FOUR: w_alu_b = 32'd4;
            default:     w_alu_b = 32'd0;
        endcase
    end

    // funct7[5] selects sub only for register-register ops; addi reuses that bit as immediate
    always_comb begin
        w_alu_ctrl = c_ALU_ADD;
        case (w_alu_op)
            c_ALUOP_SUB: w_alu_ctrl = c_ALU_SUB;
            c_ALUOP_FUNCT: begin
                case (w_funct3)
                    3'b000:  w_alu_ctrl = ((opcode == c_OPC_OP) && w_funct7_b5) ? c_ALU_SUB
                                                                                 : c_ALU_ADD;
                    3'b010:  w_alu_ctrl = c_ALU_SLT;
                    3'b100:  w_alu_ctrl = c_ALU_XOR;
                    3'b110:  w_alu_ctrl = c_ALU_OR;
                    3'b111:  w_alu_ctrl = c_ALU_AND;
                    default: w_alu_ctrl = c_ALU_ADD;
                endcase
            end
            default: w_alu_ctrl = c_ALU_ADD;
        endcase
    end

    riscv_mc_alu alu (
        .a      (w_alu_a),
        .b      (w_alu_b),
        .i_ctrl (w_alu_ctrl),
        .out    (w_alu_out),
        .o_zero (w_alu_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_result <= 32'd0;
            r_data       <= 32'd0;
        end else begin
            r_alu_result <= w_alu_out;
            r_data       <= i_mem_rdata;
        end
    end

    assign o_mem_addr  = w_addr_src ? r_alu_result : w_pc_cur;
    assign o_mem_wdata = w_rd2;
    assign o_mem_we    = w_mem_write;
endmodule

module riscv_multicycle_top #(
    parameter int MEM_WORDS = 1024
) (
    input logic clk,
    input logic reset
);
    logic [31:0] w_mem_addr, w_mem_wdata, w_mem_rdata;
    logic        w_mem_we;

    riscv_mc_core core (
        .clk         (clk),
        .reset       (reset),
        .i_mem_rdata (w_mem_rdata),
        .o_mem_addr  (w_mem_addr),
        .o_mem_wdata (w_mem_wdata),
        .o_mem_we    (w_mem_we)
    );

    riscv_mc_memory #(.MEM_WORDS(MEM_WORDS)) memory (
        .clk     (clk),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .i_we    (w_mem_we),
        .o_rdata (w_mem_rdata)
    );
endmodule

`default_nettype wire

// File: tb/tb_riscv_multicycle_top.sv
`default_nettype none
// ============================================================================
// tb_riscv_multicycle_top
// Directed program checks of the multi-cycle CPU via its internal hierarchy.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_multicycle_top;
    import riscv_mc_pkg::*;

    localparam logic [3:0] S_FETCH      = 4'd0;
    localparam logic [3:0] S_DECODE     = 4'd1;
    localparam logic [3:0] S_MEMWB      = 4'd4;
    localparam logic [3:0] S_EXECUTER   = 4'd6;
    localparam logic [3:0] S_ALUWB      = 4'd8;
    localparam logic [3:0] S_BRANCH     = 4'd9;
    localparam logic [3:0] S_JALR_CALC  = 4'd11;
    localparam logic [3:0] S_JALR_STEP2 = 4'd12;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    riscv_multicycle_top #(.MEM_WORDS(1024)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- JALR, positive immediate ----
        dut.core.RegFile.RFMem[0] = 32'd0;
        dut.core.RegFile.RFMem[2] = 32'd100;
        dut.memory.M[0] = 32'h005100E7;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("rst_pc", dut.core.fetch.pc_cur, 32'd0);
        check("rst_pc_update", 32'(dut.core.cfsm__pc_update), 32'd0);
        steps(1);
        check("rst_hold_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        reset = 1'b1;
        steps(1);
        check("j1_decode_state", 32'(dut.core.control_fsm.current_state), 32'(S_DECODE));
        check("j1_opcode", 32'(dut.core.opcode), 32'h67);
        check("j1_rs1", 32'(dut.core.instruction_decode.rs1), 32'd2);
        check("j1_rd", 32'(dut.core.instruction_decode.rd), 32'd1);
        check("j1_imm", dut.core.instruction_decode.imm_ext, 32'd5);
        steps(1);
        check("j1_calc_state", 32'(dut.core.control_fsm.current_state), 32'(S_JALR_CALC));
        check("j1_calc_a", dut.core.alu.a, 32'd100);
        check("j1_calc_b", dut.core.alu.b, 32'd5);
        check("j1_calc_out", dut.core.alu.out, 32'd105);
        steps(1);
        check("j1_step2_state", 32'(dut.core.control_fsm.current_state), 32'(S_JALR_STEP2));
        check("j1_step2_pc_update", 32'(dut.core.cfsm__pc_update), 32'd1);
        check("j1_step2_pc_src", 32'(dut.core.cfsm__pc_src), 32'(PC_SRC__ALU_RESULT));
        check("j1_step2_a", dut.core.alu.a, 32'd0);
        check("j1_step2_b", dut.core.alu.b, 32'd4);
        check("j1_step2_out", dut.core.alu.out, 32'd4);
        steps(1);
        check("j1_aluwb_state", 32'(dut.core.control_fsm.current_state), 32'(S_ALUWB));
        steps(1);
        check("j1_fetch_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("j1_x1", dut.core.RegFile.RFMem[1], 32'd4);
        check("j1_pc", dut.core.fetch.pc_cur, 32'd104);

        // ---- JALR, negative odd immediate ----
        reset = 1'b0;
        dut.core.RegFile.RFMem[1] = 32'd0;
        dut.core.RegFile.RFMem[2] = 32'd200;
        dut.memory.M[0] = 32'hFF9100E7;
        steps(1);
        reset = 1'b1;
        steps(1);
        check("j2_imm", dut.core.instruction_decode.imm_ext, 32'hFFFF_FFF9);
        steps(1);
        check("j2_calc_out", dut.core.alu.out, 32'd193);
        steps(3);
        check("j2_fetch_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("j2_pc", dut.core.fetch.pc_cur, 32'd192);
        check("j2_x1", dut.core.RegFile.RFMem[1], 32'd4);

        // ---- addi / add / sw / lw ----
        reset = 1'b0;
        dut.core.RegFile.RFMem[3] = 32'd0;
        dut.core.RegFile.RFMem[4] = 32'd0;
        dut.core.RegFile.RFMem[5] = 32'd0;
        dut.memory.M[16] = 32'd0;
        dut.memory.M[0] = 32'h00700193;   // addi x3, x0, 7
        dut.memory.M[1] = 32'h00318233;   // add  x4, x3, x3
        dut.memory.M[2] = 32'h04402023;   // sw   x4, 64(x0)
        dut.memory.M[3] = 32'h04002283;   // lw   x5, 64(x0)
        steps(1);
        reset = 1'b1;
        steps(3);
        check("addi_aluwb_state", 32'(dut.core.control_fsm.current_state), 32'(S_ALUWB));
        steps(1);
        check("addi_fetch_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("addi_x3", dut.core.RegFile.RFMem[3], 32'd7);
        check("addi_pc", dut.core.fetch.pc_cur, 32'd4);
        steps(2);
        check("add_exec_state", 32'(dut.core.control_fsm.current_state), 32'(S_EXECUTER));
        check("add_exec_out", dut.core.alu.out, 32'd14);
        steps(2);
        check("add_fetch_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("add_x4", dut.core.RegFile.RFMem[4], 32'd14);
        check("add_pc", dut.core.fetch.pc_cur, 32'd8);
        steps(4);
        check("sw_fetch_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("sw_mem16", dut.memory.M[16], 32'd14);
        check("sw_pc", dut.core.fetch.pc_cur, 32'd12);
        steps(4);
        check("lw_memwb_state", 32'(dut.core.control_fsm.current_state), 32'(S_MEMWB));
        steps(1);
        check("lw_fetch_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("lw_x5", dut.core.RegFile.RFMem[5], 32'd14);
        check("lw_pc", dut.core.fetch.pc_cur, 32'd16);

        // ---- x0 write ignored, NOP, beq taken ----
        reset = 1'b0;
        dut.memory.M[0] = 32'h00500013;   // addi x0, x0, 5
        dut.memory.M[1] = 32'h00000000;   // unsupported opcode -> NOP
        dut.memory.M[2] = 32'hFE000CE3;   // beq x0, x0, -8
        steps(1);
        reset = 1'b1;
        steps(4);
        check("x0_pc", dut.core.fetch.pc_cur, 32'd4);
        check("x0_value", dut.core.RegFile.RFMem[0], 32'd0);
        steps(1);
        check("nop_decode_state", 32'(dut.core.control_fsm.current_state), 32'(S_DECODE));
        steps(1);
        check("nop_fetch_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("nop_pc", dut.core.fetch.pc_cur, 32'd8);
        steps(2);
        check("beq_branch_state", 32'(dut.core.control_fsm.current_state), 32'(S_BRANCH));
        check("beq_pc_update", 32'(dut.core.cfsm__pc_update), 32'd1);
        steps(1);
        check("beq_fetch_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("beq_pc", dut.core.fetch.pc_cur, 32'd0);

        // ---- bne not taken, then async reset mid-DECODE ----
        reset = 1'b0;
        dut.memory.M[2] = 32'hFE001CE3;   // bne x0, x0, -8
        steps(1);
        reset = 1'b1;
        steps(8);
        check("bne_pc_update", 32'(dut.core.cfsm__pc_update), 32'd0);
        steps(1);
        check("bne_fetch_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("bne_pc", dut.core.fetch.pc_cur, 32'd12);
        steps(1);
        check("pre_rst_state", 32'(dut.core.control_fsm.current_state), 32'(S_DECODE));
        check("pre_rst_pc", dut.core.fetch.pc_cur, 32'd16);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
        check("async_rst_pc", dut.core.fetch.pc_cur, 32'd0);
        check("async_rst_x5_kept", dut.core.RegFile.RFMem[5], 32'd14);
        check("async_rst_mem_kept", dut.memory.M[16], 32'd14);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
